// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: widths, engine opcodes
// and the legality check used by the bypass, writeback and error logic.
package alu_seq_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int REG_AW_DEF   = 2;
  localparam int NUM_REGS_DEF = 4;

  localparam logic [2:0] OP_OR   = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_NOR  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;

  // Opcodes 110 and 111 have no engine function; they flag an error and never
  // update architectural state.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op < 3'b110);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Small register file: NUM_REGS x DATA_W, two combinational read ports and one
// synchronous write port. No entry is hardwired; all entries clear on reset.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int REG_AW   = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Single write port; the whole array is cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/writeback stage in front of the combinational arithmetic engine.
// EX flops drive the engine directly; WB captures the engine result, writes it
// back to the register file and offers it downstream under backpressure.
// A result leaving EX is bypassed to the operand read of the instruction
// accepted on the same edge, so dependent instructions issue back-to-back.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int REG_AW   = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic [REG_AW-1:0] in_dst,
  input  logic [REG_AW-1:0] in_src_a,
  input  logic [REG_AW-1:0] in_src_b,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] eng_a,
  output logic [DATA_W-1:0] eng_b,
  output logic [2:0]        eng_opcode,
  input  logic [DATA_W-1:0] eng_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_dst,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              busy
);

  logic              ex_valid;
  logic [REG_AW-1:0] ex_dst;
  logic              wb_valid;
  logic              wb_free;
  logic              ex_adv;
  logic              accept;
  logic              ex_legal;
  logic [DATA_W-1:0] rf_rd_a;
  logic [DATA_W-1:0] rf_rd_b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  assign wb_free   = !wb_valid || out_ready;
  assign ex_adv    = ex_valid && wb_free;
  assign in_ready  = !ex_valid || wb_free;
  assign accept    = in_valid && in_ready;
  assign ex_legal  = is_legal_op(eng_opcode);
  assign out_valid = wb_valid;
  assign busy      = ex_valid || wb_valid;

  alu_seq_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (ex_adv && ex_legal),
    .wr_addr   (ex_dst),
    .wr_data   (eng_result),
    .rd_addr_a (in_src_a),
    .rd_data_a (rf_rd_a),
    .rd_addr_b (in_src_b),
    .rd_data_b (rf_rd_b)
  );

  // Operand select: forward the result leaving EX this edge, else the regfile
  always_comb begin
    op_a = rf_rd_a;
    op_b = rf_rd_b;
    if (ex_adv && ex_legal && (ex_dst == in_src_a)) begin
      op_a = eng_result;
    end
    if (ex_adv && ex_legal && (ex_dst == in_src_b)) begin
      op_b = eng_result;
    end
    if (in_use_imm) begin
      op_b = in_imm;
    end
  end

  // EX stage: load on accept, empty out when it advances with nothing behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_dst     <= '0;
      eng_a      <= '0;
      eng_b      <= '0;
      eng_opcode <= '0;
    end else if (accept) begin
      ex_valid   <= 1'b1;
      ex_dst     <= in_dst;
      eng_a      <= op_a;
      eng_b      <= op_b;
      eng_opcode <= in_opcode;
    end else if (ex_adv) begin
      ex_valid   <= 1'b0;
    end
  end

  // WB stage: capture the engine result on advance, drain on out_ready, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      out_dst  <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else if (ex_adv) begin
      wb_valid <= 1'b1;
      out_dst  <= ex_dst;
      out_data <= ex_legal ? eng_result : '0;
      out_err  <= !ex_legal;
    end else if (out_ready) begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Issue/writeback stage directly upstream of the combinational arithmetic_engine (8-bit A/B, 3-bit opcode, 8-bit result; 000 OR, 001 NAND, 010 NOR, 011 AND, 100 ADD, 101 SUB).
- Accepts instructions over a valid/ready handshake and reads operands from a small register file or an immediate.
- Drives the engine from a registered EX stage and captures the engine result into a WB stage.
- Writes the result back to the register file and presents it downstream with backpressure.

Parameters:
DATA_W, 8, operand/result width; must match arithmetic_engine.
NUM_REGS, 4, register-file entries.
REG_AW, 2, register index width, equal to log2(NUM_REGS).

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction offered
in_ready  out  1  instruction accepted when in_valid && in_ready
in_opcode  in  3  engine opcode
in_dst  in  REG_AW  destination register
in_src_a  in  REG_AW  operand A register
in_src_b  in  REG_AW  operand B register (ignored if in_use_imm)
in_use_imm  in  1  B comes from in_imm
in_imm  in  DATA_W  immediate B value
eng_a  out  DATA_W  to engine A
eng_b  out  DATA_W  to engine B
eng_opcode  out  3  to engine opcode
eng_result  in  DATA_W  from engine result, combinational
out_valid  out  1  WB result available
out_ready  in  1  downstream accepts
out_dst  out  REG_AW  destination of WB result
out_data  out  DATA_W  WB result
out_err  out  1  WB entry had an illegal opcode
busy  out  1  ex_valid || wb_valid

Behaviour:
- Reset (async assert, sync release): ex_valid, wb_valid, eng_a/b/opcode, out_dst/data/err cleared to 0; all registers cleared to 0. in_ready=1 during and after reset.
- Two pipeline registers:
  - EX holds ex_valid, eng_a, eng_b, eng_opcode, ex_dst; eng_* are driven directly from these flops.
  - WB holds wb_valid, out_data, out_dst, out_err; out_valid = wb_valid.
- Handshake and advance rules:
  - wb_free = !wb_valid || out_ready.
  - ex_adv = ex_valid && wb_free.
  - in_ready = !ex_valid || wb_free (combinational, no dependence on in_valid).
- Accept: EX loads the new instruction.
  - eng_a = operand(in_src_a).
  - eng_b = in_use_imm ? in_imm : operand(in_src_b).
- Operand read is combinational from the register file, with a bypass: if ex_adv, ex_dst==src and the EX opcode is legal, return eng_result instead of the register file.
- ex_adv:
  - WB captures eng_result, ex_dst and err=(eng_opcode>=3'b110).
  - The register file writes eng_result to ex_dst on the same edge, only if the opcode is legal.
  - If WB drains with no EX advance, wb_valid clears.
- Hold: with no accept, EX holds and eng_* stay stable. With out_valid && !out_ready, WB holds all outputs unchanged.
- Latency: instruction accepted at edge N → eng_* valid after N → out_valid after N+1. Throughput is 1 per cycle with no bubbles, including dependent back-to-back instructions (bypass).
- Illegal opcode 110/111: passed to the engine; WB out_data forced 0x00, out_err=1; no register write.
- Arithmetic: mod 2^DATA_W, carry/borrow discarded (0xFF+0x01=0x00, 0x00-0x01=0xFF); computed by the engine only.
- Ordering: results leave in acceptance order; nothing is dropped or duplicated under any out_ready pattern.
- Reset mid-operation: in-flight EX/WB contents discarded; out_valid drops asynchronously.
- No register is hardwired to zero. The idiom "OR rX ← r0 | imm" loads a constant only while r0 is 0.

Decomposition:
- Package alu_seq_pkg: opcode localparams (OP_OR, OP_NAND, OP_NOR, OP_AND, OP_ADD, OP_SUB), an is_legal_op function, DATA_W/REG_AW defaults.
- One sub-module: alu_seq_regfile (NUM_REGS×DATA_W, async reset, 2 combinational read ports, 1 write port). The bypass mux stays in the top.

Test Plan:
- Reset: assert rst_n=0 mid-stream → out_valid=0, busy=0, in_ready=1, eng_*=0; a later read of r1 gives 0x00.
- Single op: OR dst=r1 src_a=r0 imm=0x0F at edge N → eng_a=0x00, eng_b=0x0F, eng_opcode=000 in cycle N+1; out_valid=1, out_dst=1, out_data=0x0F in cycle N+2.
- Dependent back-to-back: r1=0x0F, then next cycle ADD r2←r1+imm 0x01 → eng_a=0x0F via bypass, out_data=0x10; then SUB r3←r2−r2 → 0x00. in_ready stays 1 throughout.
- Backpressure: out_ready=0 for 3 cycles while issuing OR 0xAA, AND, NOR:
  - WB holds the first result.
  - EX holds the second with eng_* stable.
  - in_ready=0 for the third.
  - After release, outputs arrive in order with correct values.
- Wrap: ADD r1←r0+0xFF then ADD r1←r1+0x01 → 0xFF, then 0x00; SUB r2←r0−0x01 → 0xFF.
- Illegal opcode 3'b110 to dst r1 holding 0x0F → out_err=1, out_data=0x00; a following OR r2←r1|0x00 returns 0x0F (r1 unchanged, no bypass).
